// File: rtl/mger_pkg.sv
// Shared types and constants for the MGER high-block datapath helpers.
// The divider FSM states and default operand widths live here.
package mger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;

    localparam logic [DEF_DW-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/high_block_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] i_rem,
    input  logic          i_qMsb,
    input  logic [VW-1:0] i_div,
    output logic [VW-1:0] o_nextRem,
    output logic          o_qBit
);

    logic [VW:0] w_shifted;
    logic [VW:0] w_trial;

    // The remainder never reaches the divisor, so VW bits hold it after
    // either branch; only the trial difference needs the extra sign bit.
    assign w_shifted = {i_rem, i_qMsb};
    assign w_trial   = w_shifted - {1'b0, i_div};
    assign o_qBit    = ~w_trial[VW];
    assign o_nextRem = w_trial[VW] ? w_shifted[VW-1:0] : w_trial[VW-1:0];

endmodule

// File: rtl/high_block_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on
// both sides, with a dedicated all-ones result for a zero divisor.
module high_block_divider
    import mger_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    state_t          r_state;
    logic [DW-1:0]   r_q;
    logic [VW-1:0]   r_rem;
    logic [VW-1:0]   r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_inReady;
    logic            r_outValid;
    logic            r_dz;

    logic [VW-1:0]   w_nextRem;
    logic            w_qBit;

    div_step #(
        .VW(VW)
    ) u_step (
        .i_rem     (r_rem),
        .i_qMsb    (r_q[DW-1]),
        .i_div     (r_div),
        .o_nextRem (w_nextRem),
        .o_qBit    (w_qBit)
    );

    // A zero divisor enters DONE with out_valid still low and raises it one
    // cycle later, so its result appears one edge after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt     <= '0;
                        r_div     <= divisor;
                        r_inReady <= 1'b0;
                        if (divisor != '0) begin
                            r_q     <= dividend;
                            r_rem   <= '0;
                            r_dz    <= 1'b0;
                            r_state <= BUSY;
                        end else begin
                            r_q     <= '1;
                            r_rem   <= dividend[VW-1:0];
                            r_dz    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r_q   <= {r_q[DW-2:0], w_qBit};
                    r_rem <= w_nextRem;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DW - 1)) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_high_block_divider.sv
// Scoreboard bench for high_block_divider: expected results are queued on
// every accept and compared against a plain arithmetic model on each result.
module tb_high_block_divider;
    import mger_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    high_block_divider #(.DW(8), .VW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai   = int'(a);
        bi   = int'(b);
        e.a  = a;
        e.b  = b;
        if (bi == 0) begin
            e.q  = DZ_QUOTIENT;
            e.r  = a[3:0];
            e.dz = 1'b1;
        end else begin
            e.q  = 8'(ai / bi);
            e.r  = 4'(ai % bi);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic sendOp(input logic [7:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            dividend = a;
            divisor  = b;
            in_valid = 1'b1;
            sb.push_back(model(a, b));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic getResult(output logic [7:0] q, output logic [3:0] r,
                             output logic dz, output int lat, output bit ok);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok  = out_valid;
        lat = n;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL result_timeout: out_valid=%0b required 1", out_valid);
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d dz=%0b required rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta[7] = '{8'd200, 8'd143, 8'd5, 8'd255, 8'd225, 8'd100, 8'd100};
        logic [3:0] tb[7] = '{4'd7, 4'd11, 4'd9, 4'd1, 4'd15, 4'd0, 4'd3};
        for (int i = 0; i < 7; i++) begin
            logic [7:0] q;
            logic [3:0] r;
            logic       dz;
            int         lat;
            int         needLat;
            bit         ok;
            exp_t       e;
            sendOp(ta[i], tb[i]);
            getResult(q, r, dz, lat, ok);
            if (!ok || sb.size() == 0) continue;
            e = sb.pop_front();
            needLat = (e.b == 4'd0) ? 1 : 8;
            checks++;
            if (q !== e.q || r !== e.r || dz !== e.dz) begin
                errors++;
                $display("[TB] FAIL directed %0d/%0d: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                         e.a, e.b, q, r, dz, e.q, e.r, e.dz);
            end
            checks++;
            if (lat != needLat) begin
                errors++;
                $display("[TB] FAIL latency %0d/%0d: got %0d cycles required %0d", e.a, e.b, lat, needLat);
            end
            if (e.b != 4'd0) begin
                checks++;
                if (int'(q) * int'(e.b) + int'(r) != int'(e.a) || r >= e.b) begin
                    errors++;
                    $display("[TB] FAIL invariant %0d/%0d: q*d+r=%0d r=%0d required %0d with r<%0d",
                             e.a, e.b, int'(q) * int'(e.b) + int'(r), r, e.a, e.b);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        int         n = 0;
        int         spurious = 0;
        bit         ok;
        exp_t       e;
        sendOp(8'd200, 4'd7);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = model(8'd200, 4'd7);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                dividend = 8'd9;
                divisor  = 4'd2;
                in_valid = 1'b1;
            end
            if (i == 10) in_valid = 1'b0;
            checks++;
            if (quotient !== e.q || remainder !== e.r || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold cycle %0d: q=%0d r=%0d vld=%0b rdy=%0b required q=%0d r=%0d vld=1 rdy=0",
                         i, quotient, remainder, out_valid, in_ready, e.q, e.r);
            end
            @(negedge clk);
        end
        getResult(q, r, dz, lat, ok);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q || r !== e.r || dz !== e.dz) begin
                errors++;
                $display("[TB] FAIL backpressure_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                         q, r, dz, e.q, e.r, e.dz);
            end
        end
        for (int i = 0; i < 15; i++) begin
            if (out_valid) spurious++;
            @(negedge clk);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("[TB] FAIL backpressure_no_extra: out_valid high %0d cycles required 0", spurious);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        int         spurious = 0;
        bit         ok;
        exp_t       e;
        sendOp(8'd255, 4'd2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midop_reset: rdy=%0b vld=%0b q=%0d r=%0d dz=%0b required rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) spurious++;
            @(negedge clk);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("[TB] FAIL midop_discard: out_valid high %0d cycles required 0", spurious);
        end
        sendOp(8'd255, 4'd2);
        getResult(q, r, dz, lat, ok);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q || r !== e.r || dz !== e.dz) begin
                errors++;
                $display("[TB] FAIL midop_rerun: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                         q, r, dz, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        int   issued = 0;
        int   received = 0;
        int   cyc = 0;
        int   lastAccept = -1;
        int   needGap;
        logic [3:0] lastB = '0;
        bit   pendingLoad = 1'b0;
        exp_t e;
        dividend  = 8'($urandom);
        divisor   = 4'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (received < N && cyc < 15000) begin
            if (pendingLoad) begin
                pendingLoad = 1'b0;
                if (issued == N) begin
                    in_valid = 1'b0;
                end else begin
                    dividend = 8'($urandom);
                    divisor  = (issued < 16) ? 4'(issued) : 4'($urandom_range(0, 15));
                end
            end
            if (out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                    errors++;
                    $display("[TB] FAIL random %0d/%0d: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                             e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                end
                received++;
            end
            if (in_ready && in_valid) begin
                sb.push_back(model(dividend, divisor));
                if (lastAccept >= 0) begin
                    needGap = (lastB == 4'd0) ? 3 : 10;
                    checks++;
                    if (cyc - lastAccept != needGap) begin
                        errors++;
                        $display("[TB] FAIL accept_spacing: got %0d cycles required %0d", cyc - lastAccept, needGap);
                    end
                end
                lastAccept  = cyc;
                lastB       = divisor;
                issued++;
                pendingLoad = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (received != N || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_count: received=%0d pending=%0d required received=%0d pending=0",
                     received, sb.size(), N);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
